// File: rtl/core_sequencer.sv
// Instruction sequencer: fetch/decode/execute/memory/writeback FSM that qualifies decoder
// strobes, owns the imem/dmem request handshakes, PC update timing and interrupt entry.
module core_sequencer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic       o_imem_req,
  input  logic       i_imem_ready,
  output logic       o_ir_we,
  input  logic       i_dec_rf_wen,
  input  logic       i_dec_dm_wen,
  input  logic       i_dec_is_load,
  input  logic       i_dec_csr_wen,
  input  logic       i_dec_mret,
  output logic       o_dmem_req,
  output logic       o_dmem_we,
  input  logic       i_dmem_ready,
  output logic       o_rf_wen,
  output logic       o_csr_wen,
  output logic       o_pc_we,
  output logic [1:0] o_pc_sel,
  input  logic       i_irq_pending,
  input  logic       i_irq_enable,
  output logic       o_trap_enter,
  output logic       o_trap_return,
  output logic       o_instret,
  output logic       o_bus_fault,
  output logic [2:0] o_state_dbg
);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6,
    ST_FAULT  = 3'd7
  } state_t;

  localparam logic [7:0] LP_LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_wait_cnt;
  logic       r_bus_fault;
  logic       w_timeout;
  logic       w_irq;
  logic       w_mem_op;

  assign w_timeout   = (r_wait_cnt == LP_LAST_WAIT);
  assign w_irq       = i_irq_pending & i_irq_enable;
  assign w_mem_op    = i_dec_is_load | i_dec_dm_wen;
  assign o_state_dbg = r_state;
  assign o_bus_fault = r_bus_fault;

  // Handshake: a request is held high every cycle until the matching ready is seen in the
  // same cycle; ready without a request is ignored, and a pending request is dropped on reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_RESET;
      r_wait_cnt  <= 8'd0;
      r_bus_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_wait_cnt <= 8'd0;
      else if (r_state == ST_FETCH || r_state == ST_MEM)
        r_wait_cnt <= r_wait_cnt + 8'd1;
      if (w_next == ST_FAULT)
        r_bus_fault <= 1'b1;
    end
  end

  // Ready on the last allowed wait cycle wins over the timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RESET:  w_next = ST_FETCH;
      ST_FETCH:  if (i_imem_ready) w_next = ST_DECODE;
                 else if (w_timeout) w_next = ST_FAULT;
      ST_DECODE: w_next = ST_EXEC;
      ST_EXEC:   if (w_mem_op) w_next = ST_MEM;
                 else if (w_irq && !i_dec_mret) w_next = ST_TRAP;
                 else w_next = ST_FETCH;
      ST_MEM:    if (i_dmem_ready) w_next = ST_WB;
                 else if (w_timeout) w_next = ST_FAULT;
      ST_WB:     w_next = w_irq ? ST_TRAP : ST_FETCH;
      ST_TRAP:   w_next = ST_FETCH;
      ST_FAULT:  w_next = ST_FAULT;
      default:   w_next = ST_RESET;
    endcase
  end

  always_comb begin
    o_imem_req    = 1'b0;
    o_ir_we       = 1'b0;
    o_dmem_req    = 1'b0;
    o_dmem_we     = 1'b0;
    o_rf_wen      = 1'b0;
    o_csr_wen     = 1'b0;
    o_pc_we       = 1'b0;
    o_pc_sel      = 2'b00;
    o_trap_enter  = 1'b0;
    o_trap_return = 1'b0;
    o_instret     = 1'b0;
    case (r_state)
      ST_FETCH: begin
        o_imem_req = 1'b1;
        o_ir_we    = i_imem_ready;
      end
      ST_EXEC: begin
        if (!w_mem_op) begin
          o_rf_wen      = i_dec_rf_wen;
          o_csr_wen     = i_dec_csr_wen;
          o_pc_we       = 1'b1;
          o_instret     = 1'b1;
          o_trap_return = i_dec_mret;
          o_pc_sel      = i_dec_mret ? 2'b10 : 2'b00;
        end
      end
      ST_MEM: begin
        o_dmem_req = 1'b1;
        o_dmem_we  = i_dec_dm_wen;
      end
      ST_WB: begin
        o_rf_wen  = i_dec_is_load;
        o_pc_we   = 1'b1;
        o_instret = 1'b1;
      end
      ST_TRAP: begin
        o_pc_we      = 1'b1;
        o_pc_sel     = 2'b01;
        o_trap_enter = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: per-cycle vector table for instruction flows plus
// hand-written timeout and reset sequences.
module tb_core_sequencer;

  logic       clk;
  logic       rst_n;
  logic       imem_req, imem_ready, ir_we;
  logic       dec_rf_wen, dec_dm_wen, dec_is_load, dec_csr_wen, dec_mret;
  logic       dmem_req, dmem_we, dmem_ready;
  logic       rf_wen, csr_wen, pc_we;
  logic [1:0] pc_sel;
  logic       irq_pending, irq_enable;
  logic       trap_enter, trap_return, instret, bus_fault;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  core_sequencer #(.TIMEOUT_CYCLES(255)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_imem_req(imem_req), .i_imem_ready(imem_ready), .o_ir_we(ir_we),
    .i_dec_rf_wen(dec_rf_wen), .i_dec_dm_wen(dec_dm_wen), .i_dec_is_load(dec_is_load),
    .i_dec_csr_wen(dec_csr_wen), .i_dec_mret(dec_mret),
    .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .i_dmem_ready(dmem_ready),
    .o_rf_wen(rf_wen), .o_csr_wen(csr_wen), .o_pc_we(pc_we), .o_pc_sel(pc_sel),
    .i_irq_pending(irq_pending), .i_irq_enable(irq_enable),
    .o_trap_enter(trap_enter), .o_trap_return(trap_return), .o_instret(instret),
    .o_bus_fault(bus_fault), .o_state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // input masks
  localparam logic [9:0] I_NONE = 10'h000;
  localparam logic [9:0] I_RST  = 10'h200;
  localparam logic [9:0] I_IMR  = 10'h100;
  localparam logic [9:0] I_DMR  = 10'h080;
  localparam logic [9:0] I_RF   = 10'h040;
  localparam logic [9:0] I_DM   = 10'h020;
  localparam logic [9:0] I_LD   = 10'h010;
  localparam logic [9:0] I_CSR  = 10'h008;
  localparam logic [9:0] I_MRET = 10'h004;
  localparam logic [9:0] I_IRQ  = 10'h002;
  localparam logic [9:0] I_IEN  = 10'h001;

  // output masks
  localparam logic [12:0] O_NONE = 13'h0000;
  localparam logic [12:0] O_IMQ  = 13'h1000;
  localparam logic [12:0] O_IRWE = 13'h0800;
  localparam logic [12:0] O_DMQ  = 13'h0400;
  localparam logic [12:0] O_DMWE = 13'h0200;
  localparam logic [12:0] O_RF   = 13'h0100;
  localparam logic [12:0] O_CSR  = 13'h0080;
  localparam logic [12:0] O_PCWE = 13'h0040;
  localparam logic [12:0] O_SELM = 13'h0020;
  localparam logic [12:0] O_SELT = 13'h0010;
  localparam logic [12:0] O_TE   = 13'h0008;
  localparam logic [12:0] O_TR   = 13'h0004;
  localparam logic [12:0] O_IR   = 13'h0002;
  localparam logic [12:0] O_BF   = 13'h0001;

  localparam logic [2:0] S_RESET = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                         S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6, S_FAULT = 3'd7;

  typedef struct {
    logic [9:0]  in;
    logic [2:0]  st;
    logic [12:0] out;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [9:0] in, input logic [2:0] st, input logic [12:0] out);
    vec_t v;
    v.in  = in;
    v.st  = st;
    v.out = out;
    vecs.push_back(v);
  endfunction

  // driver: inputs change on the falling edge, outputs sampled 1 time unit later
  task automatic apply(input logic [9:0] in);
    @(negedge clk);
    rst_n       = ~in[9];
    imem_ready  = in[8];
    dmem_ready  = in[7];
    dec_rf_wen  = in[6];
    dec_dm_wen  = in[5];
    dec_is_load = in[4];
    dec_csr_wen = in[3];
    dec_mret    = in[2];
    irq_pending = in[1];
    irq_enable  = in[0];
    #1;
  endtask

  // scoreboard
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [2:0] st, input logic [12:0] out);
    logic [15:0] got;
    logic [15:0] want;
    exp_q.push_back({st, out});
    want = exp_q.pop_front();
    got  = {state_dbg, imem_req, ir_we, dmem_req, dmem_we, rf_wen, csr_wen, pc_we, pc_sel,
            trap_enter, trap_return, instret, bus_fault};
    n_checks++;
    if (got !== want || (imem_req && dmem_req)) begin
      n_errors++;
      $display("FAIL %s: got state=%0d outs=%04h, expected state=%0d outs=%04h",
               name, got[15:13], got[12:0], want[15:13], want[12:0]);
    end
  endtask

  initial begin
    apply(I_RST);
    apply(I_RST);

    // reset hold/release
    add(I_RST, S_RESET, O_NONE);
    add(I_NONE, S_RESET, O_NONE);
    // ADD, imem_ready tied 1
    add(I_IMR | I_RF, S_FETCH, O_IMQ | O_IRWE);
    add(I_IMR | I_RF, S_DECODE, O_NONE);
    add(I_IMR | I_RF, S_EXEC, O_RF | O_PCWE | O_IR);
    // LW, dmem_ready after 2 wait cycles
    add(I_IMR | I_LD | I_RF, S_FETCH, O_IMQ | O_IRWE);
    add(I_LD | I_RF, S_DECODE, O_NONE);
    add(I_LD | I_RF, S_EXEC, O_NONE);
    add(I_LD | I_RF, S_MEM, O_DMQ);
    add(I_LD | I_RF, S_MEM, O_DMQ);
    add(I_LD | I_RF | I_DMR, S_MEM, O_DMQ);
    add(I_LD | I_RF, S_WB, O_RF | O_PCWE | O_IR);
    // SW, dmem_ready immediately
    add(I_IMR | I_DM, S_FETCH, O_IMQ | O_IRWE);
    add(I_DM, S_DECODE, O_NONE);
    add(I_DM, S_EXEC, O_NONE);
    add(I_DM | I_DMR, S_MEM, O_DMQ | O_DMWE);
    add(I_DM, S_WB, O_PCWE | O_IR);
    // ADD with irq; irq ignored during fetch/decode
    add(I_IMR | I_RF | I_IRQ | I_IEN, S_FETCH, O_IMQ | O_IRWE);
    add(I_RF | I_IRQ | I_IEN, S_DECODE, O_NONE);
    add(I_RF | I_IRQ | I_IEN, S_EXEC, O_RF | O_PCWE | O_IR);
    add(I_IRQ | I_IEN, S_TRAP, O_PCWE | O_SELT | O_TE);
    // MRET with irq pending: deferred to the following CSR instruction
    add(I_IMR | I_MRET | I_IRQ | I_IEN, S_FETCH, O_IMQ | O_IRWE);
    add(I_MRET | I_IRQ | I_IEN, S_DECODE, O_NONE);
    add(I_MRET | I_IRQ | I_IEN, S_EXEC, O_PCWE | O_SELM | O_TR | O_IR);
    add(I_IMR | I_IRQ | I_IEN, S_FETCH, O_IMQ | O_IRWE);
    add(I_IRQ | I_IEN, S_DECODE, O_NONE);
    add(I_CSR | I_IRQ | I_IEN, S_EXEC, O_CSR | O_PCWE | O_IR);
    add(I_NONE, S_TRAP, O_PCWE | O_SELT | O_TE);
    // SW with irq: not taken mid-access, taken at WB
    add(I_IMR | I_DM, S_FETCH, O_IMQ | O_IRWE);
    add(I_DM, S_DECODE, O_NONE);
    add(I_DM | I_IRQ, S_EXEC, O_NONE);
    add(I_DM | I_DMR | I_IRQ | I_IEN, S_MEM, O_DMQ | O_DMWE);
    add(I_DM | I_IRQ | I_IEN, S_WB, O_PCWE | O_IR);
    add(I_NONE, S_TRAP, O_PCWE | O_SELT | O_TE);
    // reset pulsed during MEM
    add(I_IMR | I_LD, S_FETCH, O_IMQ | O_IRWE);
    add(I_LD, S_DECODE, O_NONE);
    add(I_LD, S_EXEC, O_NONE);
    add(I_LD | I_RST, S_MEM, O_DMQ);
    add(I_LD | I_DMR, S_RESET, O_NONE);
    add(I_NONE, S_FETCH, O_IMQ);

    foreach (vecs[i]) begin
      apply(vecs[i].in);
      check($sformatf("vec%0d", i), vecs[i].st, vecs[i].out);
    end

    // fetch timeout: 255 waiting cycles then FAULT
    apply(I_RST);
    apply(I_NONE);
    check("tmo_reset", S_RESET, O_NONE);
    for (int k = 0; k < 254; k++) begin
      apply(I_NONE);
      if (k == 0 || k == 253) check($sformatf("tmo_wait%0d", k), S_FETCH, O_IMQ);
    end
    apply(I_NONE);
    check("tmo_last", S_FETCH, O_IMQ);
    apply(I_IMR);
    check("tmo_fault", S_FAULT, O_BF);
    apply(I_IMR | I_DMR | I_RF);
    check("tmo_sticky", S_FAULT, O_BF);
    apply(I_RST);
    check("tmo_rst_edge", S_FAULT, O_BF);
    apply(I_NONE);
    check("tmo_cleared", S_RESET, O_NONE);

    // ready on the 255th cycle wins
    for (int k = 0; k < 254; k++) apply(I_NONE);
    apply(I_IMR);
    check("tmo_ready_last", S_FETCH, O_IMQ | O_IRWE);
    apply(I_LD);
    check("tmo_decode", S_DECODE, O_NONE);
    apply(I_LD);
    check("mem_exec", S_EXEC, O_NONE);

    // data timeout in MEM
    for (int k = 0; k < 254; k++) begin
      apply(I_LD);
      if (k == 0) check("mem_wait0", S_MEM, O_DMQ);
    end
    apply(I_LD);
    check("mem_last", S_MEM, O_DMQ);
    apply(I_LD | I_DMR);
    check("mem_fault", S_FAULT, O_BF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
